// File: rtl/nuc_packer.sv
// Packs a stream of 2-bit nucleotides LSB-first into 512-bit words for the
// shift-register load path; flush closes a partial word with outLast set.
module nuc_packer #(
    parameter int DATA_W = 512,
    parameter int SYM_W  = 2,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SYM_W-1:0]  inNuc,
    input  logic              nucValid,
    output logic              nucReady,
    input  logic              flush,
    output logic [DATA_W-1:0] outData,
    output logic              outValid,
    input  logic              outReady,
    output logic [CNT_W-1:0]  outCount,
    output logic              outLast
);

    // state      | meaning
    // IDLE       | accumulator empty, no flush pending
    // FILL       | accumulator holds 1..255 nucleotides
    // FLUSH_WAIT | flushed partial word parked in acc until output register frees
    typedef enum logic [1:0] {IDLE, FILL, FLUSH_WAIT} state_t;

    localparam int SYMS = DATA_W / SYM_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SYMS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYMS - 1);

    state_t            state, state_d;
    logic [DATA_W-1:0] acc, acc_ins, acc_d;
    logic [CNT_W-1:0]  acc_cnt, cnt_ins, cnt_d, load_cnt;
    logic              out_free, take, close, load, load_last;

    assign out_free = !outValid || outReady;
    assign nucReady = ((acc_cnt != LAST_CNT) || out_free) && (state != FLUSH_WAIT);
    assign take     = nucValid && nucReady;

    always_comb begin
        acc_ins = acc;
        if (take) acc_ins[SYM_W*acc_cnt +: SYM_W] = inNuc;
        cnt_ins   = acc_cnt + {{(CNT_W-1){1'b0}}, take};
        acc_d     = acc_ins;
        cnt_d     = cnt_ins;
        state_d   = state;
        close     = 1'b0;
        load      = 1'b0;
        load_last = 1'b0;
        load_cnt  = cnt_ins;
        case (state)
            FLUSH_WAIT: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_last = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                // a full word only completes when out_free, so only flush can stall
                close = (cnt_ins == FULL_CNT) || (flush && (cnt_ins != '0));
                if (close && out_free) begin
                    load      = 1'b1;
                    load_last = flush;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (close) begin
                    state_d = FLUSH_WAIT;
                end else begin
                    state_d = (cnt_ins == '0) ? IDLE : FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            acc      <= '0;
            acc_cnt  <= '0;
            outData  <= '0;
            outCount <= '0;
            outLast  <= 1'b0;
            outValid <= 1'b0;
        end else begin
            state   <= state_d;
            acc     <= acc_d;
            acc_cnt <= cnt_d;
            if (load) begin
                outData  <= acc_ins;
                outCount <= load_cnt;
                outLast  <= load_last;
                outValid <= 1'b1;
            end else if (outReady) begin
                outValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nuc_packer.sv
// Self-checking bench for nuc_packer: directed table, hand-written corner
// sequences and random traffic against a word-queue reference model.
module tb_nuc_packer;

    logic         clk, rst, nucValid, nucReady, flush, outValid, outReady, outLast;
    logic [1:0]   inNuc;
    logic [511:0] outData;
    logic [8:0]   outCount;

    nuc_packer dut (
        .clk(clk), .rst(rst), .inNuc(inNuc), .nucValid(nucValid), .nucReady(nucReady),
        .flush(flush), .outData(outData), .outValid(outValid), .outReady(outReady),
        .outCount(outCount), .outLast(outLast)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [511:0] d;
        int           cnt;
        bit           last;
    } word_t;

    typedef struct {
        logic        nv;
        logic [1:0]  nuc;
        logic        fl;
        logic        ordy;
        logic        e_rdy;
        logic        e_val;
        logic [8:0]  e_cnt;
        logic        e_last;
        logic [15:0] e_lo;
    } vec_t;

    word_t      exp_q[$];
    logic [1:0] cur[$];
    int         checks = 0;
    int         errors = 0;
    int         words_out = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic nv, input logic [1:0] nuc, input logic fl, input logic ordy);
        nucValid = nv;
        inNuc    = nuc;
        flush    = fl;
        outReady = ordy;
        #1;
    endtask

    // Check handshake outputs against the model, then account for the coming edge.
    task automatic advance();
        int    pend;
        bit    exp_rdy, take, oxf;
        word_t w;
        pend    = exp_q.size();
        exp_rdy = (pend < 2) && !(cur.size() == 255 && pend == 1 && !outReady);
        chk("nucReady", nucReady, exp_rdy);
        chk("outValid", outValid, pend > 0);
        take = nucValid && nucReady;
        oxf  = outValid && outReady;
        if (oxf) begin
            words_out++;
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                chk("outData", outData, w.d);
                chk("outCount", outCount, w.cnt);
                chk("outLast", outLast, w.last);
            end
        end
        if (take) cur.push_back(inNuc);
        if (cur.size() == 256 || (flush && cur.size() > 0)) begin
            w.d = '0;
            foreach (cur[i]) w.d[2*i +: 2] = cur[i];
            w.cnt  = cur.size();
            w.last = flush;
            exp_q.push_back(w);
            cur.delete();
        end
        @(negedge clk);
    endtask

    task automatic step(input logic nv, input logic [1:0] nuc, input logic fl, input logic ordy);
        apply(nv, nuc, fl, ordy);
        advance();
    endtask

    vec_t tbl[$];
    int   k, base;
    logic [511:0] e564;

    initial begin
        rst = 1'b0;
        nucValid = 1'b0; inNuc = 2'd0; flush = 1'b0; outReady = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        apply(0, 0, 0, 1);
        chk("rst_outValid", outValid, 0);
        chk("rst_outCount", outCount, 0);
        chk("rst_outLast", outLast, 0);
        chk("rst_outData", outData, 0);
        chk("rst_nucReady", nucReady, 1);

        // partial flush, same-cycle flush, empty flush
        tbl.push_back('{1, 3, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 3, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 3, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 3, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 1, 1, 5, 1, 16'h01FF});
        tbl.push_back('{0, 0, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 3, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 3, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 3, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 3, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 1, 1, 5, 1, 16'h01FF});
        tbl.push_back('{0, 0, 1, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 1, 0, 0, 0, 0});
        foreach (tbl[i]) begin
            apply(tbl[i].nv, tbl[i].nuc, tbl[i].fl, tbl[i].ordy);
            chk($sformatf("tbl%0d_rdy", i), nucReady, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_valid", i), outValid, tbl[i].e_val);
            if (tbl[i].e_val) begin
                chk($sformatf("tbl%0d_count", i), outCount, tbl[i].e_cnt);
                chk($sformatf("tbl%0d_last", i), outLast, tbl[i].e_last);
                chk($sformatf("tbl%0d_data", i), outData, {496'd0, tbl[i].e_lo});
            end
            advance();
        end

        // full word of repeating 0,1,2,3
        for (int i = 0; i < 256; i++) step(1, 2'(i), 0, 1);
        apply(0, 0, 0, 1);
        e564 = {64{8'hE4}};
        chk("s1_valid", outValid, 1);
        chk("s1_data", outData, e564);
        chk("s1_count", outCount, 256);
        chk("s1_last", outLast, 0);
        advance();

        // backpressure: 511 accepted, then stall until the output frees
        k = 0;
        for (int i = 0; i < 520; i++) begin
            apply(1, 2'($urandom), 0, 0);
            if (nucReady) k++;
            advance();
        end
        chk("s2_accepted", k, 511);
        apply(1, 2'($urandom), 0, 0);
        chk("s2_stalled", nucReady, 0);
        advance();
        apply(1, 2'($urandom), 0, 1);
        chk("s2_resume", nucReady, 1);
        advance();
        apply(0, 0, 0, 1);
        chk("s2_second_valid", outValid, 1);
        chk("s2_second_count", outCount, 256);
        advance();
        repeat (2) step(0, 0, 0, 1);

        // flush stall behind a held word
        step(1, 2, 0, 0);
        step(1, 1, 0, 0);
        step(1, 3, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 2'($urandom), i == 9, 0);
        apply(0, 0, 0, 0);
        chk("s5_rdy_wait", nucReady, 0);
        advance();
        repeat (3) step(1, 1, 1, 0);
        step(0, 0, 0, 1);
        apply(0, 0, 0, 1);
        chk("s5_count", outCount, 10);
        chk("s5_last", outLast, 1);
        chk("s5_rdy", nucReady, 1);
        advance();

        // reset mid-operation
        for (int i = 0; i < 5; i++) step(1, 2'($urandom), i == 4, 0);
        for (int i = 0; i < 100; i++) step(1, 2'($urandom), 0, 0);
        apply(0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("s6_valid_async", outValid, 0);
        exp_q.delete();
        cur.delete();
        @(negedge clk);
        rst = 1'b1;
        base = words_out;
        for (int i = 0; i < 256; i++) step(1, 2'($urandom), 0, 1);
        repeat (3) step(0, 0, 0, 1);
        chk("s6_words", words_out - base, 1);

        // random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) != 0);
        step(0, 0, 1, 1);
        repeat (4) step(0, 0, 0, 1);
        chk("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
